// File: rtl/main_memory_model.sv
// rtl/main_memory_model.sv - queued block-granular main memory with independent read/write latency
// Optional MEM_TRACE_EN: prints one line per accepted request and per response.
module main_memory_model #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int BLOCK_SIZE    = 16,
    parameter int READ_LATENCY  = 100,
    parameter int WRITE_LATENCY = 20,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                             read,
    input  logic                             write,
    output logic                             req_ready,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             ready,
    output logic                             hit,
    output logic                             resp_write
);
    localparam int MEM_WORDS = 1 << ADDR_WIDTH;
    localparam int BLK_W     = BLOCK_SIZE * DATA_WIDTH;
    localparam int PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int TIMER_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic                   ready_q, ready_d, hit_q, hit_d, resp_write_q, resp_write_d;
    logic [BLK_W-1:0]       data_out_q, data_out_d;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_WORDS];
    logic                   op_q   [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_q [QUEUE_DEPTH];
    logic [BLK_W-1:0]       data_q [QUEUE_DEPTH];

    logic                   accept, pop, head_op;
    logic [ADDR_WIDTH-1:0]  aligned, head_addr;
    logic [BLK_W-1:0]       head_data, rd_block;
    logic [TIMER_W-1:0]     head_lat;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_ready  = (count_q < CNT_W'(QUEUE_DEPTH));
    assign accept     = (read | write) & req_ready;
    assign aligned    = addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
    assign data_out   = data_out_q;
    assign ready      = ready_q;
    assign hit        = hit_q;
    assign resp_write = resp_write_q;

    // A unit-latency op responds in its own service-start cycle and never enters BUSY.
    always_comb begin
        head_op   = op_q[head_q];
        head_addr = addr_q[head_q];
        head_data = data_q[head_q];
        head_lat  = head_op ? TIMER_W'(WRITE_LATENCY) : TIMER_W'(READ_LATENCY);
        state_d   = state_q;
        timer_d   = timer_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_lat == TIMER_W'(1)) begin
                        pop = 1'b1;
                    end else begin
                        state_d = BUSY;
                        timer_d = head_lat - TIMER_W'(1);
                    end
                end
            end
            BUSY: begin
                if (timer_q == TIMER_W'(1)) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_block = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rd_block[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_addr + ADDR_WIDTH'(i)];
        end
    end

    always_comb begin
        count_d      = count_q + CNT_W'(accept) - CNT_W'(pop);
        tail_d       = accept ? next_ptr(tail_q) : tail_q;
        head_d       = pop ? next_ptr(head_q) : head_q;
        ready_d      = pop;
        hit_d        = pop & ~head_op;
        resp_write_d = pop & head_op;
        data_out_d   = (pop && !head_op) ? rd_block : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            ready_q      <= 1'b0;
            hit_q        <= 1'b0;
            resp_write_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            ready_q      <= ready_d;
            hit_q        <= hit_d;
            resp_write_q <= resp_write_d;
            data_out_q   <= data_out_d;
        end
    end

    // Write wins over read when both are asserted, so op is simply the write strobe.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q[tail_q]   <= write;
            addr_q[tail_q] <= aligned;
            data_q[tail_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= DATA_WIDTH'(i);
            end
        end else if (pop && head_op) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem_q[head_addr + ADDR_WIDTH'(i)] <= head_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef MEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (accept) begin
                if (write) $display("%0t mem accept WR addr=%h data=%h", $time, aligned, data_in);
                else       $display("%0t mem accept RD addr=%h", $time, aligned);
            end
            if (pop) begin
                if (head_op) $display("%0t mem resp WR addr=%h data=%h", $time, head_addr, head_data);
                else         $display("%0t mem resp RD addr=%h data=%h", $time, head_addr, rd_block);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_main_memory_model.sv
// tb/tb_main_memory_model.sv - scoreboard bench for main_memory_model with default parameters
module tb_main_memory_model;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int BS    = 16;
    localparam int BLK_W = DW * BS;
    localparam int RL    = 100;
    localparam int WL    = 20;

    typedef struct {
        bit             is_wr;
        logic [BLK_W-1:0] data;
        int             cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    addr;
    logic [BLK_W-1:0] data_in;
    logic             read, write;
    logic             req_ready;
    logic [BLK_W-1:0] data_out;
    logic             ready, hit, resp_write;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_resp = 0;
    exp_t expq[$];
    logic [DW-1:0] mdl [int];

    main_memory_model dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
        .read(read), .write(write), .req_ready(req_ready), .data_out(data_out),
        .ready(ready), .hit(hit), .resp_write(resp_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdl_rd(input int a);
        return mdl.exists(a) ? mdl[a] : DW'(a);
    endfunction

    function automatic logic [BLK_W-1:0] mk_block(input logic [DW-1:0] base);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = base + DW'(i);
        return b;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("hit", hit, !e.is_wr);
                chk("resp_write", resp_write, e.is_wr);
                if (!e.is_wr) chk_blk("read_data", data_out, e.data);
            end
        end
    end

    // Called at a negedge; drives one request, returns the posedge cycle it was accepted in.
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BLK_W-1:0] d, output int t_acc);
        int n;
        int al;
        exp_t e;
        n = 0;
        t_acc = -1;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                chk("req_ready_timeout", 0, 1);
                return;
            end
        end
        addr = a; data_in = d; read = rd; write = wr;
        t_acc = cyc + 1;
        al = int'(a) & ~(BS - 1);
        e.is_wr = wr;
        e.cyc = ((t_acc > last_resp) ? t_acc : last_resp) + (wr ? WL : RL);
        last_resp = e.cyc;
        e.data = '0;
        if (wr) begin
            for (int i = 0; i < BS; i++) mdl[al + i] = d[i*DW +: DW];
        end else begin
            for (int i = 0; i < BS; i++) e.data[i*DW +: DW] = mdl_rd(al + i);
        end
        expq.push_back(e);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", expq.size(), 0);
    endtask

    initial begin
        int t, t1, t5, rdy_cnt;
        rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_hit", hit, 0);
        chk("rst_resp_write", resp_write, 0);
        chk_blk("rst_data_out", data_out, '0);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 1'b0, 16'h0013, '0, t);
        drain();

        issue(1'b0, 1'b1, 16'h0040, mk_block(32'hA0), t);
        issue(1'b1, 1'b0, 16'h0047, '0, t);
        drain();
        chk_blk("write_then_read_hold", data_out, mk_block(32'hA0));

        issue(1'b1, 1'b0, 16'h0100, '0, t1);
        issue(1'b1, 1'b0, 16'h0110, '0, t);
        issue(1'b1, 1'b0, 16'h0120, '0, t);
        issue(1'b1, 1'b0, 16'h0130, '0, t);
        chk("req_ready_full", req_ready, 0);
        issue(1'b1, 1'b0, 16'h0140, '0, t5);
        chk("fifth_accept_cycle", t5, t1 + RL + 1);
        drain();

        issue(1'b1, 1'b1, 16'h0020, mk_block(32'h55), t);
        drain();
        issue(1'b1, 1'b0, 16'h0020, '0, t);
        drain();

        issue(1'b1, 1'b0, 16'hFFF0, '0, t);
        drain();

        issue(1'b1, 1'b0, 16'h0200, '0, t);
        issue(1'b1, 1'b0, 16'h0210, '0, t);
        issue(1'b1, 1'b0, 16'h0220, '0, t);
        repeat (48) @(negedge clk);
        rst_n = 1'b0;
        expq.delete();
        mdl.delete();
        last_resp = 0;
        repeat (2) @(negedge clk);
        chk("midrst_ready", ready, 0);
        chk_blk("midrst_data_out", data_out, '0);
        rst_n = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
        end
        chk("no_ready_after_reset", rdy_cnt, 0);
        chk("req_ready_after_reset", req_ready, 1);
        issue(1'b1, 1'b0, 16'h0040, '0, t);
        issue(1'b1, 1'b0, 16'h0020, '0, t);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_memory_model.md
# main_memory_model

Parametrised, queued main-memory model that sits below the L2 cache and serves block-granular reads and writes with configurable, independent read and write latencies. It accepts up to `QUEUE_DEPTH` outstanding requests through a valid/ready handshake and serves them strictly in order. Each request completes with a one-cycle response pulse. It replaces the fixed-latency, read-only memory model, adding write support, back-pressure and tunable latency for L2 miss and writeback testing.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per word.
- `ADDR_WIDTH`, 16: word-address width; memory holds `1<<ADDR_WIDTH` words.
- `BLOCK_SIZE`, 16: words per block, power of two, ≥2.
- `READ_LATENCY`, 100: cycles from service start to read response, ≥1.
- `WRITE_LATENCY`, 20: cycles from service start to write response, ≥1.
- `QUEUE_DEPTH`, 4: maximum outstanding requests, including the one in service; ≥1.

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `addr`, input, `ADDR_WIDTH`: request word address. The low `$clog2(BLOCK_SIZE)` bits are ignored, so the address is block-aligned.
- `data_in`, input, `BLOCK_SIZE`×`DATA_WIDTH`: write block. Word i is carried in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `read`, input, 1: read request.
- `write`, input, 1: write request.
- `req_ready`, output, 1: queue can accept a request this cycle.
- `data_out`, output, `BLOCK_SIZE`×`DATA_WIDTH`: read block, using the same packing as `data_in`.
- `ready`, output, 1: one-cycle response pulse, for reads and writes.
- `hit`, output, 1: high with `ready` for read responses only.
- `resp_write`, output, 1: high with `ready` for write responses only.

## Operation
- **Accept.** A request is accepted in cycle T when `(read|write) && req_ready`. The queue stores `{op, aligned addr, data_in}`.
- **Simultaneous read and write.** Write has priority; exactly one write request is enqueued and the read is dropped.
- **Back-pressure.** `req_ready = (count < QUEUE_DEPTH)`, combinational from the registered count. There is no pass-through when full: a response in the same cycle does not raise `req_ready` until the next cycle.
- **Service FSM.** States are IDLE and BUSY.
  - IDLE→BUSY when the queue is non-empty. The timer is loaded with the latency of the head op, and that cycle is the service start S.
  - BUSY decrements the timer each cycle. In cycle S+L−1 it issues the response, pops the head, and returns to IDLE.
  - Requests are served in order; there is no reordering or read/write merging.
- **Write response.** In the response cycle, all `BLOCK_SIZE` words are written to `mem[aligned+i]`. `ready=1`, `resp_write=1`, `hit=0`, and `data_out` is unchanged.
- **Read response.** In the response cycle, `data_out` is registered from `mem[aligned+i]` as it stands at that edge. `ready=1` and `hit=1`. A read queued behind a write to the same block returns the written data.
- `data_out` holds its value until the next read response.
- **Reset.** Reset outputs are `ready=0`, `hit=0`, `resp_write=0`, `data_out=0`, `count=0` (so `req_ready=1`), and FSM in IDLE. Memory is initialised to `mem[i]=i`, truncated to `DATA_WIDTH`.
- **Reset mid-operation.** A reset during operation drops every queued and in-service request with no response, and re-initialises memory.
- Addresses wrap at `1<<ADDR_WIDTH`; since blocks are aligned, a block never straddles the wrap.

## Timing
- **Idle unit.** Request accepted at T gives S=T+1, so the response is at T+L (L = `READ_LATENCY` or `WRITE_LATENCY`).
- **Queued request.** S is the cycle after the previous response, so back-to-back responses are spaced exactly L of the later op apart.
- Accept and pop in the same cycle leave `count` unchanged.
- Throughput is one request per L cycles. Acceptance is one per cycle until the queue is full.
- `ready`, `hit` and `resp_write` are never high for two consecutive cycles when L>1.

## Configuration
- `MEM_TRACE_EN`
  - **Defined:** every accept and every response prints one `$display` line with `$time`, op, aligned address, and data (for writes and read responses).
  - **Undefined:** no display statements are compiled, and cycle behaviour is identical.

## Test plan
- Reset, then read `addr=0x0013` with default parameters → `ready`/`hit` are high exactly 100 cycles after accept. `data_out` word i = 0x10+i and `resp_write=0`.
- Write block at 0x0040 with words 0xA0+i, then immediately read 0x0047 → write response at T+20, then read response 100 cycles later with words 0xA0+i. `hit` is high only on the read.
- Issue 5 back-to-back reads with `QUEUE_DEPTH=4` → `req_ready` drops after the 4th accept, and the 5th is held until the cycle after the first response. Five responses arrive in order, spaced 100 cycles apart.
- Assert `read` and `write` together at 0x0020 → a single write response and no read response.
- Read 0xFFF0 with `ADDR_WIDTH=16` → words 0xFFF0..0xFFFF, with no wrap into block 0.
- Assert reset 50 cycles into a read with 2 queued → no `ready` for 300 cycles after reset, `req_ready=1`, and memory back to `mem[i]=i`.
